// File: rtl/neuron_mac_if.sv
// Streaming bus of the neuron MAC: weighted-input beats upstream and the
// sign/magnitude pre-activation result downstream, each with valid/ready.
interface neuron_mac_if #(
    parameter int DATA_W = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic signed [DATA_W-1:0] in_weight;
    logic signed [DATA_W-1:0] bias;
    logic                     out_valid;
    logic                     out_ready;
    logic        [DATA_W-1:0] out_x;
    logic                     out_neg;

    modport master (
        output in_valid, in_data, in_weight, bias, out_ready,
        input  in_ready, out_valid, out_x, out_neg
    );

    modport slave (
        input  in_valid, in_data, in_weight, bias, out_ready,
        output in_ready, out_valid, out_x, out_neg
    );
endinterface

// File: rtl/neuron_mac.sv
// Neuron pre-activation: bias + sum of N_INPUTS Q6.10 products, emitted as a
// saturated magnitude plus sign. Define NEURON_MAC_ROUND_EN for round-half-up.
module neuron_mac #(
    parameter int N_INPUTS = 4,
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 10,
    parameter int ACC_W    = 40
) (
    input  logic          clk,
    input  logic          rst_n,
    neuron_mac_if.slave   bus
);
    localparam int CNT_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int PROD_W = 2 * DATA_W;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);
    localparam logic [ACC_W-1:0] MAX_MAG  = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
`ifdef NEURON_MAC_ROUND_EN
    localparam logic signed [ACC_W-1:0] HALF_LSB =
        {{(ACC_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
`endif

    typedef enum logic {ACC, OUT} state_t;

    state_t                    state, state_next;
    logic        [CNT_W-1:0]   count;
    logic signed [ACC_W-1:0]   acc;
    logic        [DATA_W-1:0]  x_q;
    logic                      neg_q;

    logic                      beat;
    logic                      last_beat;
    logic signed [PROD_W-1:0]  data_ext, weight_ext, prod;
    logic signed [ACC_W-1:0]   prod_ext, bias_ext, acc_base, acc_sum, acc_rnd, s;
    logic        [ACC_W-1:0]   mag;
    logic        [DATA_W-1:0]  x_next;
    logic                      neg_next;

    assign beat      = bus.in_valid && bus.in_ready;
    assign last_beat = beat && (count == LAST_CNT);

    // Operands are widened first so the product is a full-width signed Q12.20.
    assign data_ext   = {{DATA_W{bus.in_data[DATA_W-1]}}, bus.in_data};
    assign weight_ext = {{DATA_W{bus.in_weight[DATA_W-1]}}, bus.in_weight};
    assign prod       = data_ext * weight_ext;
    assign prod_ext   = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign bias_ext   = {{(ACC_W-DATA_W){bus.bias[DATA_W-1]}}, bus.bias};

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        acc_base = acc;
        if (count == '0) begin
            acc_base = bias_ext <<< FRAC_W;
        end
        acc_sum = acc_base + prod_ext;
    end

`ifdef NEURON_MAC_ROUND_EN
    assign acc_rnd = acc_sum + HALF_LSB;
`else
    assign acc_rnd = acc_sum;
`endif

    // A zero s naturally yields neg = 0 and mag = 0, so no special case is needed.
    always_comb begin
        s        = acc_rnd >>> FRAC_W;
        neg_next = s[ACC_W-1];
        mag      = neg_next ? ACC_W'(-s) : ACC_W'(s);
        x_next   = mag[DATA_W-1:0];
        if (mag > MAX_MAG) begin
            x_next = MAX_MAG[DATA_W-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ACC: if (last_beat)     state_next = OUT;
            OUT: if (bus.out_ready) state_next = ACC;
            default:                state_next = ACC;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == ACC);
        bus.out_valid = (state == OUT);
        bus.out_x     = x_q;
        bus.out_neg   = neg_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            acc   <= '0;
            x_q   <= '0;
            neg_q <= 1'b0;
        end else if (beat) begin
            acc <= acc_sum;
            if (last_beat) begin
                count <= '0;
                x_q   <= x_next;
                neg_q <= neg_next;
            end else begin
                count <= count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: hand-computed Q6.10 neurons covering sign,
// saturation, rounding, bubbles, output backpressure and mid-neuron reset.
module tb_neuron_mac;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    neuron_mac_if #(.DATA_W(16)) bus ();

    neuron_mac #(
        .N_INPUTS(4),
        .DATA_W  (16),
        .FRAC_W  (10),
        .ACC_W   (40)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one beat and returns one step after the edge on which it transferred.
    task automatic send_beat(input logic signed [15:0] d, input logic signed [15:0] w,
                             input logic signed [15:0] b);
        logic ok;
        ok            = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_weight = w;
        bus.bias      = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.in_ready) ok = 1'b1;
            tick();
        end
        chk("beat_accept", {31'd0, ok}, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_neuron(input logic signed [15:0] d, input logic signed [15:0] w,
                               input logic signed [15:0] b, input string tag);
        for (int i = 0; i < 4; i++) send_beat(d, w, b);
        chk({tag, "_latency"}, {31'd0, bus.out_valid}, 32'd1);
    endtask

    task automatic get_result(input string tag, input logic [15:0] ex, input logic eneg);
        for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, "_x"}, {16'd0, bus.out_x}, {16'd0, ex});
        chk({tag, "_neg"}, {31'd0, bus.out_neg}, {31'd0, eneg});
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_weight = '0;
        bus.bias      = '0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_x", {16'd0, bus.out_x}, 32'd0);
        chk("rst_out_neg", {31'd0, bus.out_neg}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // 4 x 1.0*1.0 = 4.0
        send_neuron(16'sd1024, 16'sd1024, 16'sd0, "unity");
        get_result("unity", 16'd4096, 1'b0);

        // 4 x 1.0*-1.0 = -4.0, then with +0.5 bias = -3.5
        send_neuron(16'sd1024, -16'sd1024, 16'sd0, "neg");
        get_result("neg", 16'd4096, 1'b1);
        send_neuron(16'sd1024, -16'sd1024, 16'sd512, "negbias");
        get_result("negbias", 16'd3584, 1'b1);

        send_neuron(16'sd32767, 16'sd32767, 16'sd0, "satpos");
        get_result("satpos", 16'd32767, 1'b0);
        send_neuron(16'sd32767, -16'sd32768, 16'sd0, "satneg");
        get_result("satneg", 16'd32767, 1'b1);

        // bias 1.0 + 1.0 - 1.0 + 3.0 + 0 = 4.0; later-beat bias values must be ignored
        send_beat(16'sd2048, 16'sd512, 16'sd1024);
        send_beat(-16'sd1024, 16'sd1024, -16'sd32768);
        send_beat(16'sd3072, 16'sd1024, 16'sd7777);
        send_beat(16'sd0, 16'sd5, 16'sd100);
        get_result("mixed", 16'd4096, 1'b0);

        // +0.5 LSB and -0.5 LSB of the output grid
        send_beat(16'sd1, 16'sd512, 16'sd0);
        for (int i = 0; i < 3; i++) send_beat(16'sd0, 16'sd0, 16'sd0);
`ifdef NEURON_MAC_ROUND_EN
        get_result("rnd_pos", 16'd1, 1'b0);
`else
        get_result("rnd_pos", 16'd0, 1'b0);
`endif
        send_beat(16'sd1, -16'sd512, 16'sd0);
        for (int i = 0; i < 3; i++) send_beat(16'sd0, 16'sd0, 16'sd0);
`ifdef NEURON_MAC_ROUND_EN
        get_result("rnd_neg", 16'd0, 1'b0);
`else
        get_result("rnd_neg", 16'd1, 1'b1);
`endif

        // Bubbles between beats leave the unity result unchanged
        for (int i = 0; i < 4; i++) begin
            send_beat(16'sd1024, 16'sd1024, 16'sd0);
            if (i < 3) begin
                tick();
                tick();
                chk("bubble_no_valid", {31'd0, bus.out_valid}, 32'd0);
            end
        end
        get_result("bubble", 16'd4096, 1'b0);

        // Output stall with a beat of the next neuron already offered
        send_neuron(16'sd1024, 16'sd1024, 16'sd0, "stall");
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'sd1024;
        bus.in_weight = 16'sd2048;
        bus.bias      = 16'sd0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_x", {16'd0, bus.out_x}, 32'd4096);
            chk("stall_neg", {31'd0, bus.out_neg}, 32'd0);
            chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("handoff_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("handoff_valid", {31'd0, bus.out_valid}, 32'd0);
        // 2.0 + 1.0 + 1.0 + 1.0 = 5.0 only if the held beat was taken exactly once
        send_beat(16'sd1024, 16'sd2048, 16'sd0);
        for (int i = 0; i < 3; i++) send_beat(16'sd1024, 16'sd1024, 16'sd0);
        get_result("after_stall", 16'd5120, 1'b0);

        // Reset after two beats discards the partial sum
        send_beat(16'sd1024, 16'sd1024, 16'sd0);
        send_beat(16'sd1024, 16'sd1024, 16'sd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("postrst_valid", {31'd0, bus.out_valid}, 32'd0);
        for (int i = 0; i < 3; i++) send_beat(16'sd512, 16'sd1024, 16'sd0);
        chk("postrst_3beats_valid", {31'd0, bus.out_valid}, 32'd0);
        send_beat(16'sd512, 16'sd1024, 16'sd0);
        chk("postrst_latency", {31'd0, bus.out_valid}, 32'd1);
        get_result("postrst", 16'd2048, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
- Upstream stage of the PLAN sigmoid activation. Computes one neuron pre-activation: bias plus N_INPUTS weighted inputs, all signed Q6.10 (1024 = 1.0).
- Output is split into a saturated unsigned magnitude `out_x` and a sign bit `out_neg`. The sigmoid consumes the magnitude, and the sign is used for symmetric reflection, f(-x) = 1 - f(x).
- Streaming valid/ready on both sides, one product per cycle.

Parameters:
- N_INPUTS, 4, number of input/weight beats per neuron (>=1)
- DATA_W, 16, width of data, weight, bias and out_x
- FRAC_W, 10, fractional bits of the Q format
- ACC_W, 40, signed accumulator width (>= 2*DATA_W + clog2(N_INPUTS+1))

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat
- in_data  in  DATA_W  signed Q6.10 activation
- in_weight  in  DATA_W  signed Q6.10 weight
- bias  in  DATA_W  signed Q6.10 bias, sampled on the first beat of each neuron
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_x  out  DATA_W  unsigned magnitude |sum|, saturated to 2^(DATA_W-1)-1
- out_neg  out  1  1 when the final sum is negative (never 1 for a zero result)

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: state = ACC, count = 0, acc = 0, out_valid = 0, out_x = 0, out_neg = 0.
- State ACC:
  - in_ready = 1, out_valid = 0.
  - A beat transfers when in_valid && in_ready.
  - product = in_data * in_weight, a full 2*DATA_W signed product in Q12.20, sign-extended to ACC_W.
  - First beat (count == 0): acc <= sign_ext(bias) <<< FRAC_W + product.
  - Later beats: acc <= acc + product.
  - count increments on every transfer.
  - On the transfer with count == N_INPUTS-1: compute the result from the final sum (including this beat), register out_x/out_neg, set out_valid, clear count, and go to OUT.
- State OUT:
  - in_ready = 0, out_valid = 1.
  - out_x and out_neg are held stable until out_valid && out_ready.
  - On the handshake: out_valid <= 0 next cycle and return to ACC.
  - No overlap: the first beat of the next neuron is accepted at the earliest in the cycle after the output handshake.
- Result computation:
  - s = final_acc >>> FRAC_W (arithmetic shift; truncates toward -inf).
  - out_neg = (s < 0).
  - mag = |s|, computed in ACC_W bits.
  - out_x = (mag > 2^(DATA_W-1)-1) ? 2^(DATA_W-1)-1 : mag.
  - If s == 0: out_neg = 0 and out_x = 0.
- Latency: out_valid rises the cycle after the final beat transfer.
- Throughput: N_INPUTS + 1 cycles per neuron minimum, with out_ready held high.
- in_valid low in ACC: no state change, acc holds (bubbles allowed between beats).
- Reset mid-accumulation: partial sum and count are discarded, and no output is produced.
- Arithmetic width: the accumulator never wraps for any input within the ACC_W rule; saturation is applied only at the output.

Optional Feature:
- Macro: NEURON_MAC_ROUND_EN.
- Defined: before the shift, add 2^(FRAC_W-1) to the final sum (round half up toward +inf), i.e. s = (final_acc + 2^(FRAC_W-1)) >>> FRAC_W.
- Undefined: plain truncating arithmetic shift as above.
- Saturation and sign rules are identical in both builds.

Test Plan:
- Unity sum: bias 0; data 1024, weight 1024 x4 -> out_x = 4096, out_neg = 0, out_valid one cycle after the 4th beat.
- Negative sum: bias 0; data 1024, weight -1024 x4 -> out_x = 4096, out_neg = 1. With bias 512: out_x = 3584, out_neg = 1.
- Saturation: data 32767, weight 32767 x4 -> out_x = 32767, out_neg = 0. Data 32767, weight -32768 x4 -> out_x = 32767, out_neg = 1.
- Rounding, for beats {1 x 512, then 0 x 0 three times}, bias 0:
  - Without macro: out_x = 0, out_neg = 0.
  - With NEURON_MAC_ROUND_EN: out_x = 1, out_neg = 0.
  - Same with weight -512: without macro out_x = 1, out_neg = 1; with macro out_x = 0, out_neg = 0.
- Backpressure and bubbles:
  - in_valid toggling between beats: result unchanged.
  - out_ready low 3 cycles: out_x/out_neg stable, in_ready = 0, no beat lost.
  - Next neuron starts the cycle after the handshake.
- Reset mid-operation: assert rst_n low after 2 beats, release, send a full 4-beat neuron -> result reflects only the post-reset beats; out_valid = 0 during and after reset until completion.
